// File: rtl/pkg_display.sv
// pkg_display
// Shared constants for the 7-segment display block: digit count, input
// width, active-low segment patterns ({g,f,e,d,c,b,a}), converter states
// and small helpers for BCD decode and double-dabble adjust.
package pkg_display;

    localparam int NUM_DIGITS = 4;
    localparam int BIN_W      = 14;
    localparam int BCD_W      = 4 * NUM_DIGITS;

    localparam logic [BIN_W-1:0] MAX_DISP = 14'd9999;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CONV = 1'b1
    } conv_state_t;

    function automatic logic [6:0] seg_of_bcd(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Add 3 to every BCD nibble that is 5 or more, ahead of the shift.
    function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/module_bin2bcd.sv
// module_bin2bcd
// Sequential double-dabble: one shift/add-3 iteration per clock, 14 in all.
// The bcd/ovf outputs hold the last completed result and are the display
// register of the block; they only change on the final iteration edge, so an
// aborted or in-flight conversion never disturbs what is shown.
//
// Ports
//   clk, rst     system clock, async active-low reset
//   start        request; taken only while idle, bin latched on that edge
//   bin[13:0]    unsigned value to convert
//   busy         conversion running (exactly 14 cycles)
//   done         one-cycle pulse on the edge bcd/ovf are loaded
//   bcd[15:0]    four BCD digits, units in [3:0]
//   ovf          latched value was above 9999
//
// state   | meaning
// --------+------------------------------------------------
// ST_IDLE | waiting for start; bcd/ovf hold last result
// ST_CONV | running iterations, iter_cnt counts down to 0
import pkg_display::*;

module module_bin2bcd (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [BCD_W-1:0] bcd,
    output logic             ovf
);

    localparam logic [3:0] ITER_LAST = 4'(BIN_W - 1);

    conv_state_t      state;
    conv_state_t      state_nxt;
    logic [3:0]       iter_cnt;
    logic [BIN_W-1:0] bin_sh;
    logic [BCD_W-1:0] bcd_work;
    logic             ovf_lat;
    logic             accept;
    logic             last_iter;
    logic [BCD_W-1:0] bcd_adj;
    logic [BCD_W-1:0] bcd_shift;
    logic [BIN_W-1:0] bin_shift;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last_iter = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = ST_CONV;
                end
            end
            ST_CONV: begin
                if (iter_cnt == 4'd0) begin
                    last_iter = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bcd_adj                = dd_adjust(bcd_work);
        {bcd_shift, bin_shift} = {bcd_adj, bin_sh} << 1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iter_cnt <= '0;
            bin_sh   <= '0;
            bcd_work <= '0;
            ovf_lat  <= 1'b0;
            done     <= 1'b0;
            bcd      <= '0;
            ovf      <= 1'b0;
        end else begin
            if (accept) begin
                bin_sh   <= bin;
                bcd_work <= '0;
                iter_cnt <= ITER_LAST;
                ovf_lat  <= (bin > MAX_DISP);
            end else if (state == ST_CONV) begin
                bin_sh   <= bin_shift;
                bcd_work <= bcd_shift;
                iter_cnt <= iter_cnt - 4'd1;
            end
            done <= last_iter;
            if (last_iter) begin
                bcd <= bcd_shift;
                ovf <= ovf_lat;
            end
        end
    end

    assign busy = (state == ST_CONV);

endmodule

// File: rtl/module_display_7seg.sv
// module_display_7seg
// Binary-to-display front end: converts a 14-bit value to four BCD digits
// via module_bin2bcd and multiplexes them onto a common-anode 4-digit
// 7-segment display with leading-zero blanking and an overflow dash pattern.
//
// Ports
//   clk, rst      system clock, async active-low reset
//   bin_i[13:0]   value to display
//   valid_i       capture request (ignored while busy_o)
//   busy_o        conversion in progress
//   done_o        one-cycle pulse when the shown value changes
//   an_o[3:0]     active-low digit enables, bit0 = units
//   seg_o[6:0]    active-low segments {g,f,e,d,c,b,a}
import pkg_display::*;

module module_display_7seg #(
    parameter int REFRESH_CNT = 27000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BIN_W-1:0]      bin_i,
    input  logic                  valid_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [NUM_DIGITS-1:0] an_o,
    output logic [6:0]            seg_o
);

    localparam int               RC_W    = (REFRESH_CNT > 1) ? $clog2(REFRESH_CNT) : 1;
    localparam logic [RC_W-1:0]  RC_LAST = RC_W'(REFRESH_CNT - 1);

    logic [BCD_W-1:0] disp_bcd;
    logic             disp_ovf;
    logic [RC_W-1:0]  refresh_cnt;
    logic [1:0]       digit_idx;
    logic [3:0]       digit;
    logic             blank;

    module_bin2bcd u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (valid_i),
        .bin   (bin_i),
        .busy  (busy_o),
        .done  (done_o),
        .bcd   (disp_bcd),
        .ovf   (disp_ovf)
    );

    // Scan timing is free-running and never touched by conversions.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            refresh_cnt <= '0;
            digit_idx   <= 2'd0;
        end else if (refresh_cnt == RC_LAST) begin
            refresh_cnt <= '0;
            digit_idx   <= digit_idx + 2'd1;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    // A digit is blanked when it and every more significant digit are zero;
    // units always shows.
    always_comb begin
        digit = 4'd0;
        blank = 1'b0;
        case (digit_idx)
            2'd0: begin
                digit = disp_bcd[3:0];
                blank = 1'b0;
            end
            2'd1: begin
                digit = disp_bcd[7:4];
                blank = (disp_bcd[15:4] == 12'd0);
            end
            2'd2: begin
                digit = disp_bcd[11:8];
                blank = (disp_bcd[15:8] == 8'd0);
            end
            default: begin
                digit = disp_bcd[15:12];
                blank = (disp_bcd[15:12] == 4'd0);
            end
        endcase
    end

    always_comb begin
        if (disp_ovf) begin
            seg_o = SEG_DASH;
        end else if (blank) begin
            seg_o = SEG_BLANK;
        end else begin
            seg_o = seg_of_bcd(digit);
        end
    end

    assign an_o = ~(4'b0001 << digit_idx);

endmodule
